// File: rtl/apbspi_pkg.sv
// apbspi_pkg: definitions shared by the APB-SPI register block and the SPI
// shift engine.
//   - Register offsets inside the 256-byte APB window (paddr[7:0]).
//   - Bit positions of the CTRL and STATUS registers.
//   - ctrl_t: the SPI configuration that the register block holds.
//   - ctrl_to_word(): packs a ctrl_t into its CTRL read-back layout.
package apbspi_pkg;

    localparam logic [7:0] CTRL_OFS   = 8'h00;
    localparam logic [7:0] STATUS_OFS = 8'h04;
    localparam logic [7:0] TXDATA_OFS = 8'h08;
    localparam logic [7:0] RXDATA_OFS = 8'h0C;

    // CTRL bits
    localparam int CTRL_EN         = 0;
    localparam int CTRL_CPOL       = 1;
    localparam int CTRL_CPHA       = 2;
    localparam int CTRL_FLUSH      = 4;
    localparam int CTRL_CLKDIV_LSB = 8;

    // STATUS bits
    localparam int ST_BUSY    = 0;
    localparam int ST_TXFULL  = 1;
    localparam int ST_TXEMPTY = 2;
    localparam int ST_RXEMPTY = 3;
    localparam int ST_RXFULL  = 4;
    localparam int ST_RXOVF   = 5;

    typedef struct packed {
        logic [7:0] clkdiv;
        logic       cpha;
        logic       cpol;
        logic       en;
    } ctrl_t;

    // FLUSH is an action bit and is never stored, so it always reads 0.
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w                         = '0;
        w[CTRL_EN]                = c.en;
        w[CTRL_CPOL]              = c.cpol;
        w[CTRL_CPHA]              = c.cpha;
        w[CTRL_CLKDIV_LSB +: 8]   = c.clkdiv;
        return w;
    endfunction

endpackage

// File: rtl/apbspi_fifo.sv
// apbspi_fifo: synchronous FIFO used for the TX and RX byte queues.
//   clk, rst     : clock, asynchronous active-high reset (pointers/count)
//   push, din    : write request and data; ignored while full
//   pop          : read request; ignored while empty
//   flush        : empties the FIFO, wins over same-cycle push/pop
//   dout         : head entry (valid while !empty)
//   full, empty  : flags derived from the current (pre-cycle) count
// DEPTH must be a power of two so the pointers wrap naturally.
module apbspi_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    import apbspi_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is rejected even when a pop frees a slot in
    // the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; the count decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/apbspi_regs.sv
// apbspi_regs: APB slave register block of the APB-SPI bridge.
//   APB side : pclk, preset (async, active-high), paddr, psel, penable,
//              pwrite, pwdata -> prdata, pready (always 1), pslverr
//   Config   : cfg_en, cfg_cpol, cfg_cpha, cfg_clkdiv from CTRL
//   TX path  : tx_valid/tx_data toward the SPI engine, tx_ready back
//   RX path  : rx_valid/rx_data pulses from the engine (no backpressure)
//   spi_busy : engine mid-transfer, folded into STATUS.BUSY
// Register map (paddr[7:0]): 0x00 CTRL, 0x04 STATUS, 0x08 TXDATA, 0x0C RXDATA.
module apbspi_regs
    import apbspi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  cfg_en,
    output logic                  cfg_cpol,
    output logic                  cfg_cpha,
    output logic [7:0]            cfg_clkdiv,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  spi_busy
);

    ctrl_t       ctrl;
    logic        rxovf;

    logic        access;
    logic [7:0]  ofs;
    logic        err;
    logic        ok;
    logic [31:0] rdata;
    logic [31:0] status;

    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]  rx_head;
    logic        tx_push, tx_pop, rx_pop;
    logic        ctrl_wr, flush, ovf_set, ovf_clr;

    // Upper address bits and unused write-data bits are deliberately ignored.
    logic        unused_bits;
    assign unused_bits = ^{paddr, pwdata[31:16]};

    assign access = psel & penable;
    assign ofs    = paddr[7:0];
    assign pready = 1'b1;

    always_comb begin
        status             = '0;
        status[ST_BUSY]    = spi_busy | ~tx_empty;
        status[ST_TXFULL]  = tx_full;
        status[ST_TXEMPTY] = tx_empty;
        status[ST_RXEMPTY] = rx_empty;
        status[ST_RXFULL]  = rx_full;
        status[ST_RXOVF]   = rxovf;
    end

    // Decode: only exact word offsets are mapped, so misaligned offsets
    // fall into the default error arm.
    always_comb begin
        err   = 1'b0;
        rdata = '0;
        case (ofs)
            CTRL_OFS:   rdata = ctrl_to_word(ctrl);
            STATUS_OFS: rdata = status;
            TXDATA_OFS: err   = ~pwrite | tx_full;
            RXDATA_OFS: begin
                err   = pwrite | rx_empty;
                rdata = {24'b0, rx_head};
            end
            default:    err   = 1'b1;
        endcase
    end

    assign ok      = access & ~err;
    assign prdata  = ok ? rdata : '0;
    assign pslverr = access & err;

    assign ctrl_wr = ok & pwrite & (ofs == CTRL_OFS);
    assign flush   = ctrl_wr & pwdata[CTRL_FLUSH];
    assign ovf_clr = ok & pwrite & (ofs == STATUS_OFS) & pwdata[ST_RXOVF];
    assign tx_push = ok & pwrite & (ofs == TXDATA_OFS);
    assign rx_pop  = ok & ~pwrite & (ofs == RXDATA_OFS);

    assign tx_valid = ctrl.en & ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign ovf_set  = rx_valid & rx_full;

    assign cfg_en     = ctrl.en;
    assign cfg_cpol   = ctrl.cpol;
    assign cfg_cpha   = ctrl.cpha;
    assign cfg_clkdiv = ctrl.clkdiv;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl  <= '0;
            rxovf <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl.en     <= pwdata[CTRL_EN];
                ctrl.cpol   <= pwdata[CTRL_CPOL];
                ctrl.cpha   <= pwdata[CTRL_CPHA];
                ctrl.clkdiv <= pwdata[CTRL_CLKDIV_LSB +: 8];
            end
            // A fresh overflow outranks a same-cycle clear.
            if (ovf_set)      rxovf <= 1'b1;
            else if (ovf_clr) rxovf <= 1'b0;
        end
    end

    apbspi_fifo #(.DATA_WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txfifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush),
        .din   (pwdata[7:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    apbspi_fifo #(.DATA_WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxfifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (rx_valid),
        .pop   (rx_pop),
        .flush (flush),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

endmodule

// File: tb/tb_apbspi_regs.sv
module tb_apbspi_regs;
    localparam int DEPTH = 4;

    logic        pclk = 1'b0;
    logic        preset;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic        cfg_en, cfg_cpol, cfg_cpha;
    logic [7:0]  cfg_clkdiv, tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, spi_busy;

    apbspi_regs #(.ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .cfg_en(cfg_en), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .cfg_clkdiv(cfg_clkdiv), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
        .rx_data(rx_data), .spi_busy(spi_busy)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queues plus the architectural register contents.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       m_en, m_cpol, m_cpha, m_ovf;
    logic [7:0] m_div;

    // Engine-side stimulus used by every cycle.
    logic       g_rdy = 1'b0, g_busy = 1'b0, g_rv = 1'b0;
    logic [7:0] g_rxd = 8'h00;

    // Last observed DUT values, for directed expectations.
    logic [31:0] last_rdata;
    logic        last_err, last_txv;
    logic [7:0]  last_txd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_en = 0; m_cpol = 0; m_cpha = 0; m_div = 0; m_ovf = 0;
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 0;
        s[0] = g_busy || (txq.size() != 0);
        s[1] = (txq.size() == DEPTH);
        s[2] = (txq.size() == 0);
        s[3] = (rxq.size() == 0);
        s[4] = (rxq.size() == DEPTH);
        s[5] = m_ovf;
        return s;
    endfunction

    // One clock: drive at the falling edge, check 1 time unit later, then
    // advance the model to the state that the next rising edge produces.
    task automatic cycle(input logic sel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        logic        acc, err, exp_txv, flush, txpop, txpush, rxpop, rxpush, ovfset, ovfclr;
        logic [7:0]  o;
        logic [31:0] rd;
        @(negedge pclk);
        psel = sel; penable = en; pwrite = wr; paddr = addr; pwdata = wd;
        tx_ready = g_rdy; rx_valid = g_rv; rx_data = g_rxd; spi_busy = g_busy;
        #1;
        acc = sel && en;
        o   = addr[7:0];
        err = 0;
        rd  = 0;
        if (o == 8'h00)      rd = {16'h0, m_div, 5'b0, m_cpha, m_cpol, m_en};
        else if (o == 8'h04) rd = model_status();
        else if (o == 8'h08) err = !wr || (txq.size() == DEPTH);
        else if (o == 8'h0C) begin
            err = wr || (rxq.size() == 0);
            if (!err) rd = {24'h0, rxq[0]};
        end else err = 1;
        exp_txv = m_en && (txq.size() != 0);

        check("prdata", prdata, (acc && !err) ? rd : 32'h0);
        check("pslverr", pslverr, acc && err);
        check("pready", pready, 1);
        check("tx_valid", tx_valid, exp_txv);
        if (exp_txv) check("tx_data", tx_data, txq[0]);
        check("cfg", {cfg_clkdiv, cfg_cpha, cfg_cpol, cfg_en}, {m_div, m_cpha, m_cpol, m_en});
        last_rdata = prdata; last_err = pslverr; last_txv = tx_valid; last_txd = tx_data;

        flush  = acc && wr && o == 8'h00 && wd[4];
        txpop  = exp_txv && g_rdy;
        txpush = acc && wr && !err && o == 8'h08;
        rxpop  = acc && !wr && !err && o == 8'h0C;
        rxpush = g_rv && (rxq.size() < DEPTH);
        ovfset = g_rv && (rxq.size() == DEPTH);
        ovfclr = acc && wr && o == 8'h04 && wd[5];
        if (acc && wr && o == 8'h00) begin
            m_en = wd[0]; m_cpol = wd[1]; m_cpha = wd[2]; m_div = wd[15:8];
        end
        if (ovfset) m_ovf = 1;
        else if (ovfclr) m_ovf = 0;
        if (flush) begin
            txq.delete();
            rxq.delete();
        end else begin
            if (txpop)  void'(txq.pop_front());
            if (txpush) txq.push_back(wd[7:0]);
            if (rxpop)  void'(rxq.pop_front());
            if (rxpush) rxq.push_back(g_rxd);
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        cycle(1, 0, wr, addr, wd);
        cycle(1, 1, wr, addr, wd);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  exp_tx [4];
        logic [31:0] a, w, r;
        logic        wr;
        exp_tx = '{8'h11, 8'h22, 8'h33, 8'h44};

        preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0; spi_busy = 0;
        model_reset();
        #3;
        check("rst_prdata", prdata, 0);
        check("rst_pslverr", pslverr, 0);
        check("rst_pready", pready, 1);
        check("rst_txvalid", tx_valid, 0);
        @(negedge pclk); @(negedge pclk);
        preset = 0;

        // Reset values of all four offsets
        apb(0, 32'h00, 0); check("rst_ctrl", last_rdata, 32'h0);
        apb(0, 32'h04, 0); check("rst_status", last_rdata, 32'h0000000C);
        apb(0, 32'h08, 0); check("txdata_rd_err", last_err, 1);
        apb(0, 32'h0C, 0); check("rxempty_rd_err", last_err, 1);
        check("rxempty_rd_data", last_rdata, 0);

        // CTRL write and read-back
        apb(1, 32'h00, 32'h00000A07);
        idle();
        check("cfg_en", cfg_en, 1);
        check("cfg_cpol", cfg_cpol, 1);
        check("cfg_cpha", cfg_cpha, 1);
        check("cfg_clkdiv", cfg_clkdiv, 8'h0A);
        apb(0, 32'h00, 0); check("ctrl_rb", last_rdata, 32'h00000A07);

        // TX fill with EN=0, overflow, then drain
        apb(1, 32'h00, 32'h00000A06);
        for (int i = 0; i < 4; i++) begin
            apb(1, 32'h08, {24'h0, exp_tx[i]});
            check("tx_push_ok", last_err, 0);
        end
        apb(0, 32'h04, 0); check("status_txfull", last_rdata, 32'h0000000B);
        apb(1, 32'h08, 32'h55); check("tx_full_err", last_err, 1);
        g_rdy = 1;
        apb(1, 32'h00, 32'h00000A07);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("tx_drain_v", last_txv, 1);
            check("tx_drain_d", last_txd, exp_tx[i]);
        end
        idle(); check("tx_drained", last_txv, 0);
        apb(0, 32'h04, 0); check("status_txempty", last_rdata, 32'h0000000C);

        // RX fill with overflow, drain, W1C
        g_rv = 1;
        for (int i = 0; i < 5; i++) begin
            g_rxd = 8'hA0 + 8'(i);
            idle();
        end
        g_rv = 0;
        apb(0, 32'h04, 0); check("status_rxovf", last_rdata, 32'h00000034);
        for (int i = 0; i < 4; i++) begin
            apb(0, 32'h0C, 0);
            check("rx_pop", last_rdata, 32'hA0 + i);
        end
        apb(0, 32'h0C, 0); check("rx_empty_err", last_err, 1);
        apb(1, 32'h04, 32'h20);
        apb(0, 32'h04, 0); check("status_w1c", last_rdata, 32'h0000000C);

        // Reset in the middle of a TX transfer
        g_rdy = 0;
        apb(1, 32'h08, 32'h61);
        apb(1, 32'h08, 32'h62);
        idle(); check("pre_rst_txv", last_txv, 1);
        #2 preset = 1;
        #1 check("async_rst_txv", tx_valid, 0);
        check("async_rst_en", cfg_en, 0);
        model_reset();
        @(negedge pclk) preset = 0;
        apb(0, 32'h04, 0); check("post_rst_status", last_rdata, 32'h0000000C);
        apb(0, 32'h00, 0); check("post_rst_ctrl", last_rdata, 32'h0);

        // Overflow set and W1C in the same cycle; then FLUSH
        g_rv = 1;
        for (int i = 0; i < 4; i++) begin g_rxd = 8'hB0 + 8'(i); idle(); end
        apb(1, 32'h04, 32'h20);
        g_rv = 0;
        apb(0, 32'h04, 0); check("ovf_set_wins", last_rdata, 32'h00000034);
        apb(1, 32'h08, 32'h71);
        apb(1, 32'h08, 32'h72);
        apb(1, 32'h00, 32'h10);
        apb(0, 32'h04, 0); check("flush_status", last_rdata, 32'h0000002C);
        apb(0, 32'h00, 0); check("flush_ctrl_rb", last_rdata, 32'h0);

        // Empty RX read racing an incoming byte
        cycle(1, 0, 0, 32'h0C, 0);
        g_rv = 1; g_rxd = 8'h5A;
        cycle(1, 1, 0, 32'h0C, 0);
        g_rv = 0;
        check("rx_race_err", last_err, 1);
        apb(0, 32'h0C, 0); check("rx_race_data", last_rdata, 32'h5A);

        // Unmapped / misaligned / upper address bits
        apb(0, 32'h10, 0); check("unmapped_err", last_err, 1);
        apb(1, 32'h02, 32'hFFFF); check("misaligned_err", last_err, 1);
        apb(0, 32'hABCD_0104, 0); check("upper_bits_ok", last_err, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            g_rdy  = 1'($urandom_range(0, 1));
            g_busy = 1'($urandom_range(0, 1));
            g_rv   = ($urandom_range(0, 3) == 0);
            g_rxd  = 8'($urandom);
            r  = $urandom;
            w  = $urandom;
            wr = 0;
            case ($urandom_range(0, 9))
                0: begin a = 32'h00; wr = 1; if ($urandom_range(0, 5) != 0) w[4] = 0; end
                1: a = 32'h00;
                2: a = 32'h04;
                3: begin a = 32'h04; wr = 1; end
                4, 5: begin a = 32'h08; wr = 1; end
                6, 7: a = 32'h0C;
                8: begin a = ($urandom_range(0, 1) != 0) ? 32'h08 : 32'h0C; wr = ~a[2]; end
                default: begin a = {24'h0, 8'($urandom)}; wr = 1'($urandom_range(0, 1)); end
            endcase
            a[31:8] = r[31:8];
            apb(wr, a, w);
            if ($urandom_range(0, 3) == 0) idle();
        end
        g_rv = 0;
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
